axi_stall_gen: RTL and testbench
================================

# axi_stall_gen

Per-channel AXI handshake stall generator for the AXI test memory. It consumes the three 5-bit transaction-control words (fast, async, delay) that the state-splitting stage produces from the PRNG state. It gates the five AXI channel handshakes (AR, R, AW, W, B) so the CPU bus interface sees randomized ready/valid timing. It also requests a fresh control word after every completed handshake.

## Interface
- DELAY_CYCLES, 4, wait cycles inserted when a channel's delay bit is set; legal range 2..31.
- STALL_CNT_W, 16, width of the stall statistics counter.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- axi_test  input  1  when 0, all latched control bits are treated as 0.
- ctrl_valid  input  1  new control words present this cycle.
- fast_axi_transaction  input  5  per-channel fast bit; bit index 0..4 = AR, R, AW, W, B.
- async_axi_transaction  input  5  per-channel ready-before-valid bit.
- delay_axi_transaction  input  5  per-channel long-delay bit.
- chan_req  input  5  per-channel request, i.e. the valid side of the channel being gated.
- chan_go  output  5  per-channel registered gate; a handshake fires when chan_req[i] & chan_go[i].
- ctrl_req  output  1  one-cycle pulse requesting the next control word.
- stall_count  output  STALL_CNT_W  saturating count of stalled cycles.

## Operation
- Control latch: on ctrl_valid, the three words are captured into 5-bit registers. With axi_test=0, the latch is forced to 0.
- Each channel runs an independent FSM with states IDLE, ARM, WAIT, GO. A channel samples its bits from the latch (registered value) only on leaving IDLE.
- IDLE (go=0):
  - if req and fast → GO.
  - elif req → WAIT with cnt = delay ? DELAY_CYCLES : 1.
  - elif async → ARM.
  - else stay in IDLE.
- ARM (go=1): fire → IDLE. A req arriving in ARM completes in the same cycle.
- WAIT (go=0): cnt decrements every cycle; cnt==1 → GO.
- GO (go=1): hold go until fire, then → IDLE.
- Fast has priority over delay. Async only affects IDLE when no req is present.
- A req that drops in WAIT or GO (a protocol violation) is ignored: go still asserts and holds until a fire occurs.
- ctrl_req: registered OR of all five fire terms, so it pulses one cycle after any fire. Simultaneous fires produce a single pulse.
- stall_count: +1 in each cycle where any channel has req=1 & go=0. It saturates at all-ones and never wraps.

## Timing
- Reset values: chan_go=0, ctrl_req=0, stall_count=0, all FSMs in IDLE, latch=0, cnt=0.
- Reset is asynchronous: asserting it mid-transaction drops chan_go in the same cycle, with no pending handshake retained.
- Latency from the req-rise cycle in IDLE to the first go=1 cycle:
  - fast: 1 cycle.
  - default: 2 cycles.
  - delay: DELAY_CYCLES+1 cycles.
  - ARM: 0 cycles (fire in the same cycle).
- After a fire, go is low for at least 1 cycle (the IDLE visit). Back-to-back fires on one channel are therefore ≥2 cycles apart.
- A ctrl_valid in the same cycle a channel leaves IDLE: that channel uses the previous latch value; the new word applies to the next transaction.

## Configuration
- AXI_STALL_STATS_EN:
  - Defined: stall_count is implemented as described.
  - Undefined: no counter logic is built and stall_count is tied to 0. All other behaviour is identical.

## Structure
- Package axi_stall_pkg holds:
  - NUM_CH=5.
  - Channel index constants CH_AR=0, CH_R=1, CH_AW=2, CH_W=3, CH_B=4.
  - The FSM state enum (IDLE, ARM, WAIT, GO).
- One sub-module, axi_stall_chan, contains the single-channel FSM and counter, with inputs fast/async/delay bits and req, and outputs go and fire. The top instantiates it NUM_CH times and adds the control latch, the ctrl_req register and the stall counter.

## Test plan
- Reset, then latch all-zero words, hold chan_req[CH_AR]=1 from cycle 0 → chan_go[0] rises in cycle 2 and fires; ctrl_req pulses in cycle 3; stall_count=2.
- Set fast=5'b00010, raise chan_req[CH_R] → go in cycle 1; no WAIT visit; stall_count=1.
- Set delay=5'b00100 with DELAY_CYCLES=4, raise chan_req[CH_AW] → go first high in cycle 5; stall_count=5. Setting fast=5'b00100 as well gives 1-cycle latency.
- Set async=5'b01000 with no req → chan_go[CH_W] high 1 cycle later. Then raise req → fire in the same cycle, go low in the next cycle.
- All five channels request simultaneously with fast=5'h1F → all fire in cycle 1 and ctrl_req pulses exactly once. With axi_test=0, the same stimulus gives 2-cycle latency on every channel.
- Assert reset during WAIT with cnt=3 → chan_go=0 immediately. After release, the FSM is in IDLE and a new req takes the full latency. Also force stall_count to all-ones-1 and run 3 stalled cycles → it saturates at all-ones.

Source files
------------

// File: rtl/axi_stall_pkg.sv
// Shared constants and FSM state type for the AXI handshake stall generator.
// Channel bit order everywhere: AR, R, AW, W, B.
package axi_stall_pkg;

  localparam int NUM_CH = 5;
  localparam int CH_AR  = 0;
  localparam int CH_R   = 1;
  localparam int CH_AW  = 2;
  localparam int CH_W   = 3;
  localparam int CH_B   = 4;

  // Wide enough for the largest legal DELAY_CYCLES (31).
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    GO   = 2'd3
  } chan_state_t;

endpackage

// File: rtl/axi_stall_chan.sv
// Single-channel stall FSM: decides when the gate for one AXI channel opens
// based on the fast/async/delay bits sampled while leaving IDLE.
module axi_stall_chan
  import axi_stall_pkg::*;
#(
  parameter int DELAY_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic fast_bit,
  input  logic async_bit,
  input  logic delay_bit,
  input  logic req,
  output logic go,
  output logic fire
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DELAY = CNT_W'(DELAY_CYCLES);

  chan_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             go_reg;

  assign go   = go_reg;
  assign fire = req & go_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      go_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      go_reg    <= (state_next == ARM) || (state_next == GO);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (req && fast_bit) begin
          state_next = GO;
        end else if (req) begin
          state_next = WAIT;
          cnt_next   = delay_bit ? CNT_DELAY : CNT_ONE;
        end else if (async_bit) begin
          state_next = ARM;
        end
      end
      // Request level is ignored once committed; only a fire releases the gate.
      ARM, GO: begin
        if (fire) state_next = IDLE;
      end
      WAIT: begin
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) state_next = GO;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/axi_stall_gen.sv
// Per-channel AXI handshake stall generator: latches control words, gates the
// five channel handshakes and requests a new word after every fire.
// Optional stall statistics counter enabled by defining AXI_STALL_STATS_EN.
module axi_stall_gen
  import axi_stall_pkg::*;
#(
  parameter int DELAY_CYCLES = 4,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   axi_test,
  input  logic                   ctrl_valid,
  input  logic [NUM_CH-1:0]      fast_axi_transaction,
  input  logic [NUM_CH-1:0]      async_axi_transaction,
  input  logic [NUM_CH-1:0]      delay_axi_transaction,
  input  logic [NUM_CH-1:0]      chan_req,
  output logic [NUM_CH-1:0]      chan_go,
  output logic                   ctrl_req,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic [NUM_CH-1:0] fast_reg, async_reg, delay_reg;
  logic [NUM_CH-1:0] test_mask;
  logic [NUM_CH-1:0] fire_vec;
  logic              ctrl_req_reg;

  assign test_mask = {NUM_CH{axi_test}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fast_reg  <= '0;
      async_reg <= '0;
      delay_reg <= '0;
    end else if (!axi_test) begin
      fast_reg  <= '0;
      async_reg <= '0;
      delay_reg <= '0;
    end else if (ctrl_valid) begin
      fast_reg  <= fast_axi_transaction;
      async_reg <= async_axi_transaction;
      delay_reg <= delay_axi_transaction;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      axi_stall_chan #(
        .DELAY_CYCLES(DELAY_CYCLES)
      ) u_chan (
        .clk      (clk),
        .reset    (reset),
        .fast_bit (fast_reg[gi]  & test_mask[gi]),
        .async_bit(async_reg[gi] & test_mask[gi]),
        .delay_bit(delay_reg[gi] & test_mask[gi]),
        .req      (chan_req[gi]),
        .go       (chan_go[gi]),
        .fire     (fire_vec[gi])
      );
    end
  endgenerate

  // Simultaneous fires collapse into one request pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ctrl_req_reg <= 1'b0;
    else       ctrl_req_reg <= |fire_vec;
  end
  assign ctrl_req = ctrl_req_reg;

`ifdef AXI_STALL_STATS_EN
  logic [STALL_CNT_W-1:0] stall_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_reg <= '0;
    end else if ((|(chan_req & ~chan_go)) && (stall_reg != '1)) begin
      stall_reg <= stall_reg + STALL_CNT_W'(1);
    end
  end
  assign stall_count = stall_reg;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_axi_stall_gen.sv
// Randomized and directed bench for axi_stall_gen against a latency-based
// reference model (each channel tracks "busy" plus cycles left before go).
module tb_axi_stall_gen;
  import axi_stall_pkg::*;

  localparam int D         = 4;
  localparam int SW        = 5;
  localparam int STALL_MAX = (1 << SW) - 1;
`ifdef AXI_STALL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, axi_test, ctrl_valid;
  logic [4:0]    fast_w, async_w, delay_w, chan_req, chan_go;
  logic          ctrl_req;
  logic [SW-1:0] stall_count;

  always #5 clk = ~clk;

  axi_stall_gen #(.DELAY_CYCLES(D), .STALL_CNT_W(SW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .axi_test             (axi_test),
    .ctrl_valid           (ctrl_valid),
    .fast_axi_transaction (fast_w),
    .async_axi_transaction(async_w),
    .delay_axi_transaction(delay_w),
    .chan_req             (chan_req),
    .chan_go              (chan_go),
    .ctrl_req             (ctrl_req),
    .stall_count          (stall_count)
  );

  int vectors = 0, miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit         m_busy[5];
  int         m_wait[5];
  logic [4:0] m_fast, m_async, m_delay;
  bit         m_ctrl_req;
  int         m_stall;
  logic [4:0] last_go;
  int         pulses;

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) begin
      m_busy[i] = 0;
      m_wait[i] = 0;
    end
    m_fast = '0; m_async = '0; m_delay = '0;
    m_ctrl_req = 0;
    m_stall = 0;
  endfunction

  function automatic logic [4:0] model_go();
    logic [4:0] g;
    for (int i = 0; i < 5; i++) g[i] = m_busy[i] && (m_wait[i] == 0);
    return g;
  endfunction

  // One clock: check at negedge, advance model at posedge, return at posedge+1.
  task automatic cycle();
    logic [4:0] go_m, fire_m;
    bit         nb[5];
    int         nw[5];
    @(negedge clk);
    go_m = model_go();
    check_val("chan_go", chan_go, go_m);
    check_val("ctrl_req", ctrl_req, m_ctrl_req);
    check_val("stall_count", stall_count, STATS ? m_stall : 0);
    last_go = chan_go;
    if (ctrl_req) pulses++;
    fire_m = chan_req & go_m;
    for (int i = 0; i < 5; i++) begin
      nb[i] = m_busy[i];
      nw[i] = m_wait[i];
      if (fire_m[i]) begin
        nb[i] = 0;
      end else if (!m_busy[i]) begin
        if (chan_req[i]) begin
          nb[i] = 1;
          if (axi_test && m_fast[i])       nw[i] = 0;   // latency 1
          else if (axi_test && m_delay[i]) nw[i] = D;   // latency D+1
          else                             nw[i] = 1;   // latency 2
        end else if (axi_test && m_async[i]) begin
          nb[i] = 1;
          nw[i] = 0;
        end
      end else if (m_wait[i] > 0) begin
        nw[i] = m_wait[i] - 1;
      end
    end
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < 5; i++) begin
        m_busy[i] = nb[i];
        m_wait[i] = nw[i];
      end
      if (((chan_req & ~go_m) != 0) && m_stall < STALL_MAX) m_stall++;
      m_ctrl_req = (fire_m != 0);
      if (!axi_test) begin
        m_fast = '0; m_async = '0; m_delay = '0;
      end else if (ctrl_valid) begin
        m_fast = fast_w; m_async = async_w; m_delay = delay_w;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    check_val("async_rst_go", chan_go, 0);
    check_val("async_rst_ctrl_req", ctrl_req, 0);
    check_val("async_rst_stall", stall_count, 0);
    model_reset();
    cycle();
    reset = 1'b0;
  endtask

  task automatic load(input logic [4:0] f, input logic [4:0] a, input logic [4:0] d);
    fast_w = f; async_w = a; delay_w = d;
    ctrl_valid = 1'b1;
    cycle();
    ctrl_valid = 1'b0;
  endtask

  // Raise requests on mask, measure cycles to first go, then idle and check side effects.
  task automatic measure(input string tag, input logic [4:0] mask, input int exp_lat);
    int lat = -1;
    pulses = 0;
    chan_req = chan_req | mask;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if ((last_go & mask) != 0) begin
        lat = k;
        break;
      end
    end
    check_val({tag, "_latency"}, lat, exp_lat);
    check_val({tag, "_all_go"}, last_go & mask, mask);
    chan_req = chan_req & ~mask;
    cycle();
    cycle();
    check_val({tag, "_pulses"}, pulses, 1);
    check_val({tag, "_stall"}, stall_count, STATS ? exp_lat : 0);
  endtask

  initial begin
    reset = 1'b1; axi_test = 1'b1; ctrl_valid = 1'b0;
    fast_w = '0; async_w = '0; delay_w = '0; chan_req = '0;
    pulses = 0; last_go = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_val("reset_go", chan_go, 0);
    check_val("reset_ctrl_req", ctrl_req, 0);
    check_val("reset_stall", stall_count, 0);
    reset = 1'b0;

    // Default, fast, delay, fast-over-delay latencies
    load(5'b00000, 5'b00000, 5'b00000);
    measure("ar_default", 5'b00001, 2);
    do_reset(); load(5'b00010, 5'b00000, 5'b00000);
    measure("r_fast", 5'b00010, 1);
    do_reset(); load(5'b00000, 5'b00000, 5'b00100);
    measure("aw_delay", 5'b00100, D + 1);
    do_reset(); load(5'b00100, 5'b00000, 5'b00100);
    measure("aw_fast_delay", 5'b00100, 1);

    // Async arming: go rises one cycle after the latch holds it, req fires at once
    do_reset(); load(5'b00000, 5'b01000, 5'b00000);
    cycle();
    check_val("w_async_pre", last_go[CH_W], 0);
    cycle();
    check_val("w_async_armed", last_go[CH_W], 1);
    measure("w_arm", 5'b01000, 0);
    async_w = '0;

    // All channels together: fast, then with axi_test off
    do_reset(); load(5'b11111, 5'b00000, 5'b00000);
    measure("all_fast", 5'b11111, 1);
    do_reset(); axi_test = 1'b0; load(5'b11111, 5'b11111, 5'b11111);
    measure("all_notest", 5'b11111, 2);
    axi_test = 1'b1;

    // Reset in WAIT with cnt=3, then a fresh transaction takes full latency
    do_reset(); load(5'b00000, 5'b00000, 5'b00100);
    chan_req[CH_AW] = 1'b1;
    cycle();
    cycle();
    do_reset();
    chan_req = '0;
    load(5'b00000, 5'b00000, 5'b00100);
    measure("aw_after_rst", 5'b00100, D + 1);

    // Req dropped after commit: go still rises and holds, reset clears it
    do_reset(); load(5'b10000, 5'b00000, 5'b00000);
    chan_req[CH_B] = 1'b1;
    cycle();
    chan_req[CH_B] = 1'b0;
    cycle();
    check_val("b_violation_go", last_go[CH_B], 1);
    cycle();
    check_val("b_violation_hold", last_go[CH_B], 1);
    do_reset();

    // Saturation of the stall counter
    load(5'b00000, 5'b00000, 5'b11111);
    chan_req = 5'b11111;
    for (int k = 0; k < 45; k++) cycle();
    check_val("stall_saturate", stall_count, STATS ? STALL_MAX : 0);
    chan_req = '0;
    do_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      chan_req   = chan_req ^ (5'($urandom) & 5'($urandom));
      ctrl_valid = ($urandom_range(0, 3) == 0);
      fast_w     = 5'($urandom);
      async_w    = 5'($urandom);
      delay_w    = 5'($urandom);
      axi_test   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
